// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file dimensions
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one storage entry with sync reset and edge-triggered write enable
module reg_cell #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/reg_file_read.sv
// reg_file_read: register file, one write port, two registered read ports with bypass
module reg_file_read
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_flag,
  input  logic        [ADDR_W-1:0] w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     rd_en,
  input  logic        [ADDR_W-1:0] r_addr_a,
  input  logic        [ADDR_W-1:0] r_addr_b,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     rd_valid
);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);
  logic signed [DATA_W-1:0] regs [NUM_REGS];
  logic signed [DATA_W-1:0] nxt_a, nxt_b;
  assign regs[0] = '0;
  genvar i;
  for (i = 1; i < NUM_REGS; i++) begin : g_cell
    reg_cell #(.W(DATA_W)) u_cell (
      .clk(clk),
      .rst(rst),
      .we (w_flag && w_addr == ADDR_W'(i)),
      .d  (w_data),
      .q  (regs[i])
    );
  end
  // bypass only on nonzero indices so r0 stays zero even while being "written"
  always_comb begin
    nxt_a = (r_addr_a == ZERO) ? '0 : (w_flag && w_addr == r_addr_a) ? w_data : regs[r_addr_a];
    nxt_b = (r_addr_b == ZERO) ? '0 : (w_flag && w_addr == r_addr_b) ? w_data : regs[r_addr_b];
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_a    <= '0;
      out_b    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        out_a <= nxt_a;
        out_b <= nxt_b;
      end
    end
endmodule

// File: tb/tb_reg_file_read.sv
// tb_reg_file_read: directed scenarios plus random traffic against an array model
module tb_reg_file_read;
  logic clk = 1'b0;
  logic rst, w_flag, rd_en;
  logic [3:0] w_addr, r_addr_a, r_addr_b;
  logic signed [15:0] w_data, out_a, out_b;
  logic rd_valid;
  int n_cmp = 0, n_err = 0;
  logic [15:0] mdl [16];
  logic [15:0] exp_a = '0, exp_b = '0;
  logic exp_v = 1'b0;

  reg_file_read dut (
    .clk(clk), .rst(rst), .w_flag(w_flag), .w_addr(w_addr), .w_data(w_data),
    .rd_en(rd_en), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .out_a(out_a), .out_b(out_b), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wf, input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra, input logic [3:0] rb);
    rst = r; w_flag = wf; w_addr = wa; w_data = wd; rd_en = re; r_addr_a = ra; r_addr_b = rb;
  endtask

  function automatic logic [15:0] peek(input logic [3:0] a);
    if (a == 0) return 16'h0000;
    if (w_flag && w_addr == a) return w_data;
    return mdl[a];
  endfunction

  task automatic tick();
    if (rst) begin
      foreach (mdl[k]) mdl[k] = '0;
      exp_a = '0; exp_b = '0; exp_v = 1'b0;
    end else begin
      exp_v = rd_en;
      if (rd_en) begin
        exp_a = peek(r_addr_a);
        exp_b = peek(r_addr_b);
      end
      if (w_flag && w_addr != 0) mdl[w_addr] = w_data;
    end
    @(posedge clk);
    #1;
    chk("out_a", out_a, exp_a);
    chk("out_b", out_b, exp_b);
    chk("rd_valid", {15'b0, rd_valid}, {15'b0, exp_v});
  endtask

  initial begin
    foreach (mdl[k]) mdl[k] = '0;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_a", out_a, 16'h0000);
    // write survives until reset wipes it; read during reset is dropped
    drive(0, 1, 5, 16'h1234, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 5, 5); tick();
    chk("rst_valid", {15'b0, rd_valid}, 16'h0000);
    drive(0, 0, 0, 0, 1, 5, 5); tick();
    chk("rst_r5", out_a, 16'h0000);
    chk("rst_valid_after", {15'b0, rd_valid}, 16'h0001);
    drive(0, 1, 3, 16'h7FFF, 0, 0, 0); tick();
    drive(0, 1, 4, 16'h8000, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 3, 4); tick();
    chk("basic_a", out_a, 16'h7FFF);
    chk("basic_b", out_b, 16'h8000);
    drive(0, 1, 6, 16'h0011, 0, 0, 0); tick();
    drive(0, 1, 6, 16'hBEEF, 1, 6, 6); tick();
    chk("bypass_a", out_a, 16'hBEEF);
    chk("bypass_b", out_b, 16'hBEEF);
    drive(0, 1, 0, 16'hFFFF, 1, 0, 6); tick();
    chk("zero_bypass", out_a, 16'h0000);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    chk("zero_read", out_a, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 4'(k), 16'(k), 0, 0, 0); tick();
    end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 1, 4'(k), 4'(k)); tick();
      chk("thru_a", out_a, 16'(k));
      chk("thru_valid", {15'b0, rd_valid}, 16'h0001);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk("hold_valid", {15'b0, rd_valid}, 16'h0000);
    chk("hold_a", out_a, 16'h0004);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 4'($urandom), 16'($urandom), 0, 0, 0); tick();
    end
    for (int k = 0; k < 16; k += 2) begin
      drive(0, 0, 0, 0, 1, 4'(k), 4'(k + 1)); tick();
    end
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 4'($urandom), 16'($urandom),
            $urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
